frame_sync_ctrl: RTL and testbench

Scheduler for the game-to-display state transfer. It replaces the free-running "copy while VS low" update with a sequenced ping-pong scheme: capture one game snapshot per game tick into the hidden bank, then swap banks only at a vertical-sync edge. The block sits in the top level between clkdiv_60hz, vga_ctrl and the staging/display register banks, and drives their load enables and bank select.

---
 rtl/frame_sync_if.sv | 32 +++
 rtl/frame_sync_ctrl.sv | 131 +++++++++++++
 tb/tb_frame_sync_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sync_if.sv
// frame_sync_if: bundle between the frame scheduler and its environment.
//   game_clk, vs        : raw asynchronous timing inputs (driven by master)
//   capture_en, commit  : one-cycle load / swap pulses (driven by slave)
//   write_bank, bank_sel: hidden-bank index and displayed-bank index
//   disp_valid, busy    : status flags
//   commit_cnt, drop_cnt: saturating statistics
interface frame_sync_if #(
  parameter int unsigned CNT_W = 8
);
  logic             game_clk;
  logic             vs;
  logic             capture_en;
  logic             write_bank;
  logic             bank_sel;
  logic             commit;
  logic             disp_valid;
  logic             busy;
  logic [CNT_W-1:0] commit_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output game_clk, vs,
    input  capture_en, write_bank, bank_sel, commit, disp_valid, busy,
           commit_cnt, drop_cnt
  );

  modport slave (
    input  game_clk, vs,
    output capture_en, write_bank, bank_sel, commit, disp_valid, busy,
           commit_cnt, drop_cnt
  );
endinterface

// File: rtl/frame_sync_ctrl.sv
// frame_sync_ctrl: ping-pong scheduler for game-to-display state transfer.
// One snapshot is captured into the hidden bank per game tick (after a settle
// delay); banks are swapped only on a vertical-sync falling edge.
// Ports:
//   clk   : system clock, sole clock of the block
//   rst_n : asynchronous active-low reset
//   bus   : frame_sync_if.slave (game_clk/vs in; pulses, bank select,
//           status and counters out)
module frame_sync_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  frame_sync_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, WAIT_VB} state_e;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  // [0],[1] synchroniser, [2] edge-detect history
  logic [2:0]       gclk_sync_q;
  logic [2:0]       vs_sync_q;

  state_e           state_q;
  logic [7:0]       settle_q;
  logic             capture_en_q;
  logic             commit_q;
  logic             bank_sel_q;
  logic             disp_valid_q;
  logic [CNT_W-1:0] commit_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic             tick;
  logic             vfall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // vs chain resets high (inactive) so reset release never looks like a vfall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gclk_sync_q <= 3'b000;
      vs_sync_q   <= 3'b111;
    end else begin
      gclk_sync_q <= {gclk_sync_q[1:0], bus.game_clk};
      vs_sync_q   <= {vs_sync_q[1:0], bus.vs};
    end
  end

  assign tick  =  gclk_sync_q[1] & ~gclk_sync_q[2];
  assign vfall = ~vs_sync_q[1]   &  vs_sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      capture_en_q <= 1'b0;
      commit_q     <= 1'b0;
      bank_sel_q   <= 1'b0;
      disp_valid_q <= 1'b0;
      commit_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      capture_en_q <= 1'b0;
      commit_q     <= 1'b0;

      // Swap lands on the edge that closes the commit cycle.
      if (commit_q) begin
        bank_sel_q   <= ~bank_sel_q;
        disp_valid_q <= 1'b1;
        commit_cnt_q <= sat_inc(commit_cnt_q);
      end

      case (state_q)
        IDLE: begin
          // vfall ignored here: display simply repeats the current frame
          if (tick) begin
            state_q  <= SETTLE;
            settle_q <= SETTLE_INIT;
          end
        end
        SETTLE: begin
          if (tick) begin
            settle_q <= SETTLE_INIT;
          end else if (settle_q == 8'd0) begin
            state_q      <= CAPTURE;
            capture_en_q <= 1'b1;
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        CAPTURE: begin
          // The capture in flight completes; a new tick supersedes it.
          if (tick) begin
            state_q    <= SETTLE;
            settle_q   <= SETTLE_INIT;
            drop_cnt_q <= sat_inc(drop_cnt_q);
          end else begin
            state_q <= WAIT_VB;
          end
        end
        WAIT_VB: begin
          if (vfall) begin
            // Snapshot gets displayed, so a coincident tick is not a drop.
            commit_q <= 1'b1;
            settle_q <= SETTLE_INIT;
            state_q  <= tick ? SETTLE : IDLE;
          end else if (tick) begin
            state_q    <= SETTLE;
            settle_q   <= SETTLE_INIT;
            drop_cnt_q <= sat_inc(drop_cnt_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.capture_en = capture_en_q;
  assign bus.commit     = commit_q;
  assign bus.bank_sel   = bank_sel_q;
  assign bus.write_bank = ~bank_sel_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.commit_cnt = commit_cnt_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed bench for frame_sync_ctrl (SETTLE_CYCLES=4, CNT_W=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_frame_sync_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   caps, cmts;

  always #5 clk = ~clk;

  frame_sync_if #(.CNT_W(8)) bus ();

  frame_sync_ctrl #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Runs n cycles, counting capture/commit pulses seen.
  task automatic run_cnt(input int n, output int c_cap, output int c_cmt);
    c_cap = 0;
    c_cmt = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.capture_en) c_cap++;
      if (bus.commit)     c_cmt++;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.game_clk = 1'b0;
    bus.vs       = 1'b1;
    cyc(3);
    chk("rst_capture_en", bus.capture_en, 0);
    chk("rst_commit",     bus.commit,     0);
    chk("rst_bank_sel",   bus.bank_sel,   0);
    chk("rst_write_bank", bus.write_bank, 1);
    chk("rst_disp_valid", bus.disp_valid, 0);
    chk("rst_busy",       bus.busy,       0);
    chk("rst_commit_cnt", bus.commit_cnt, 0);
    chk("rst_drop_cnt",   bus.drop_cnt,   0);
    rst_n = 1'b1;

    // Quiet inputs: nothing happens.
    run_cnt(1000, caps, cmts);
    chk("quiet_caps",       caps, 0);
    chk("quiet_cmts",       cmts, 0);
    chk("quiet_bank_sel",   bus.bank_sel,   0);
    chk("quiet_write_bank", bus.write_bank, 1);
    chk("quiet_disp_valid", bus.disp_valid, 0);

    // Basic tick -> capture at edge 7 -> vfall -> commit at edge 3.
    bus.game_clk = 1'b1;
    cyc(6);
    chk("t1_cap_e6",  bus.capture_en, 0);
    chk("t1_busy",    bus.busy,       1);
    cyc(1);
    chk("t1_cap_e7",  bus.capture_en, 1);
    chk("t1_wbank",   bus.write_bank, 1);
    cyc(1);
    chk("t1_cap_e8",  bus.capture_en, 0);
    cyc(22);
    bus.game_clk = 1'b0;
    cyc(70);
    chk("t1_wait_busy", bus.busy, 1);
    bus.vs = 1'b0;
    cyc(2);
    chk("t1_cmt_e2",  bus.commit, 0);
    cyc(1);
    chk("t1_cmt_e3",  bus.commit, 1);
    chk("t1_cap_not_cmt", bus.capture_en, 0);
    chk("t1_bank_pre", bus.bank_sel, 0);
    cyc(1);
    chk("t1_cmt_e4",  bus.commit,     0);
    chk("t1_bank",    bus.bank_sel,   1);
    chk("t1_wbank2",  bus.write_bank, 0);
    chk("t1_ccnt",    bus.commit_cnt, 1);
    chk("t1_dvalid",  bus.disp_valid, 1);
    chk("t1_idle",    bus.busy,       0);
    cyc(10);
    bus.vs = 1'b1;
    cyc(5);

    // Two ticks 50 cycles apart, then one vfall.
    bus.game_clk = 1'b1;
    cyc(7);
    chk("t2_cap1", bus.capture_en, 1);
    cyc(10);
    bus.game_clk = 1'b0;
    cyc(33);
    bus.game_clk = 1'b1;
    cyc(7);
    chk("t2_cap2", bus.capture_en, 1);
    chk("t2_drop", bus.drop_cnt,   1);
    cyc(1);
    bus.game_clk = 1'b0;
    cyc(20);
    bus.vs = 1'b0;
    run_cnt(4, caps, cmts);
    chk("t2_cmts", cmts, 1);
    chk("t2_ccnt", bus.commit_cnt, 2);
    chk("t2_bank", bus.bank_sel,   0);
    chk("t2_drop_after", bus.drop_cnt, 1);
    cyc(6);
    bus.vs = 1'b1;
    cyc(10);

    // Tick and vfall detected in the same WAIT_VB cycle.
    bus.game_clk = 1'b1;
    cyc(8);
    bus.game_clk = 1'b0;
    cyc(10);
    chk("t3_in_wait", bus.busy, 1);
    bus.game_clk = 1'b1;
    bus.vs       = 1'b0;
    cyc(3);
    chk("t3_cmt",  bus.commit,     1);
    chk("t3_busy", bus.busy,       1);
    cyc(1);
    chk("t3_cmt_end", bus.commit,  0);
    chk("t3_drop", bus.drop_cnt,   1);
    chk("t3_ccnt", bus.commit_cnt, 3);
    chk("t3_bank", bus.bank_sel,   1);
    cyc(2);
    chk("t3_cap_e6", bus.capture_en, 0);
    cyc(1);
    chk("t3_cap_e7", bus.capture_en, 1);
    cyc(1);
    bus.game_clk = 1'b0;
    bus.vs       = 1'b1;
    cyc(10);
    bus.vs = 1'b0;
    cyc(4);
    chk("t3_ccnt2", bus.commit_cnt, 4);
    chk("t3_bank2", bus.bank_sel,   0);
    bus.vs = 1'b1;
    cyc(10);

    // vfall in IDLE is ignored.
    bus.vs = 1'b0;
    run_cnt(8, caps, cmts);
    chk("t4_idle_cmts", cmts, 0);
    chk("t4_idle_bank", bus.bank_sel, 0);
    chk("t4_idle_busy", bus.busy,     0);
    bus.vs = 1'b1;
    cyc(5);

    // Short tick, restart tick during SETTLE plus a vfall there.
    bus.game_clk = 1'b1;
    cyc(1);
    bus.game_clk = 1'b0;
    cyc(1);
    bus.game_clk = 1'b1;
    bus.vs       = 1'b0;
    run_cnt(5, caps, cmts);
    chk("t5_settle_cmts", cmts, 0);
    chk("t5_cap_e7",      bus.capture_en, 0);
    cyc(1);
    chk("t5_cap_e8",      bus.capture_en, 0);
    cyc(1);
    chk("t5_cap_e9",      bus.capture_en, 1);
    chk("t5_bank",        bus.bank_sel,   0);
    chk("t5_ccnt",        bus.commit_cnt, 4);
    cyc(1);
    chk("t5_wait_busy",   bus.busy,       1);
    bus.game_clk = 1'b0;
    bus.vs       = 1'b1;
    cyc(5);

    // Asynchronous reset while in WAIT_VB.
    rst_n = 1'b0;
    #1;
    chk("t6_busy",   bus.busy,       0);
    chk("t6_dvalid", bus.disp_valid, 0);
    chk("t6_ccnt",   bus.commit_cnt, 0);
    chk("t6_drop",   bus.drop_cnt,   0);
    chk("t6_wbank",  bus.write_bank, 1);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    bus.vs = 1'b0;
    run_cnt(20, caps, cmts);
    chk("t6_post_cmts",   cmts, 0);
    chk("t6_post_caps",   caps, 0);
    chk("t6_post_dvalid", bus.disp_valid, 0);
    bus.vs = 1'b1;
    cyc(5);

    // 300 tick/vfall rounds: commit counter saturates.
    for (int i = 0; i < 300; i++) begin
      bus.game_clk = 1'b1;
      cyc(10);
      bus.game_clk = 1'b0;
      bus.vs       = 1'b0;
      cyc(5);
      bus.vs = 1'b1;
      cyc(3);
    end
    chk("t7_ccnt_sat", bus.commit_cnt, 255);
    chk("t7_drop",     bus.drop_cnt,   0);
    chk("t7_bank",     bus.bank_sel,   0);
    chk("t7_dvalid",   bus.disp_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
